// File: rtl/bus_mux_if.sv
// bus_mux_if: source, select and result signals of the six-source register-transfer bus
interface bus_mux_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic S0;
  logic S1;
  logic S2;
  logic [WIDTH-1:0] out;
  logic sel_err;
  modport master (output a, b, c, d, e, f, S0, S1, S2, input out, sel_err);
  modport slave (input a, b, c, d, e, f, S0, S1, S2, output out, sel_err);
endinterface

// File: rtl/bus_mux.sv
// bus_mux: six-source registered bus mux with illegal-select flag; define BUS_HOLD_INVALID_EN to hold out on select 6/7
module bus_mux #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  bus_mux_if.slave bus
);
`ifdef BUS_HOLD_INVALID_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif
  logic [2:0] sel;
  logic [WIDTH-1:0] out_d, out_q;
  logic sel_err_d, sel_err_q;
  // Decode the select; codes 6 and 7 flag an error and either clear or hold the bus
  always_comb begin
    sel = {bus.S2, bus.S1, bus.S0};
    sel_err_d = sel[2] & sel[1];
    out_d = sel == 3'd0 ? bus.a :
            sel == 3'd1 ? bus.b :
            sel == 3'd2 ? bus.c :
            sel == 3'd3 ? bus.d :
            sel == 3'd4 ? bus.e :
            sel == 3'd5 ? bus.f :
            HOLD ? out_q : '0;
  end
  // Register the bus value and error flag; reset clears both immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      sel_err_q <= sel_err_d;
    end
  end
  assign bus.out = out_q;
  assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_bus_mux.sv
// tb_bus_mux: scoreboard bench for bus_mux; stimulus pushes expected results, a monitor pops them after each edge
module tb_bus_mux;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [8:0] sb[$];
  bus_mux_if #(.WIDTH(8)) bus ();
  bus_mux #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`ifdef BUS_HOLD_INVALID_EN
  localparam logic [7:0] BAD_OUT = 8'h06;
`else
  localparam logic [7:0] BAD_OUT = 8'h00;
`endif
  localparam logic [47:0] SRC = 48'h06_05_04_03_02_01;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got out=%h sel_err=%b, want out=%h sel_err=%b", name, act[8:1], act[0], exp[8:1], exp[0]);
    else pass_cnt++;
  endtask
  task automatic set_src(input logic [47:0] src);
    {bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = src;
  endtask
  task automatic step(input logic [47:0] src, input logic [2:0] s, input logic [7:0] eo, input logic ee);
    @(negedge clk);
    set_src(src);
    {bus.S2, bus.S1, bus.S0} = s;
    sb.push_back({eo, ee});
  endtask
  initial begin
    logic [8:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        chk("scoreboard", {bus.out, bus.sel_err}, exp);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end
  initial begin
    set_src(SRC);
    {bus.S2, bus.S1, bus.S0} = 3'd3;
    #1 rst = 1'b1;
    #1 chk("reset_async", {bus.out, bus.sel_err}, 9'h000);
    @(posedge clk);
    #2 chk("reset_hold1", {bus.out, bus.sel_err}, 9'h000);
    @(posedge clk);
    #2 chk("reset_hold2", {bus.out, bus.sel_err}, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(SRC, 3'(i), 8'(i + 1), 1'b0);
    step(SRC, 3'd6, BAD_OUT, 1'b1);
    step(SRC, 3'd7, BAD_OUT, 1'b1);
    step(48'h5A_11_22_33_44_55, 3'd5, 8'h5A, 1'b0);
    step(48'h5A_11_22_33_44_55, 3'd7, BAD_OUT == 8'h00 ? 8'h00 : 8'h5A, 1'b1);
    step(48'h5A_11_22_33_44_55, 3'd2, 8'h33, 1'b0);
    step(SRC, 3'd0, 8'h01, 1'b0);
    @(posedge clk);
    #2 bus.a = 8'hAA;
    sb.push_back({8'hAA, 1'b0});
    #1 chk("latency_hold", {bus.out, bus.sel_err}, {8'h01, 1'b0});
    @(posedge clk);
    step(SRC, 3'd3, 8'h04, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midreset_clear", {bus.out, bus.sel_err}, 9'h000);
    rst = 1'b0;
    #1 chk("midreset_release", {bus.out, bus.sel_err}, 9'h000);
    step(SRC, 3'd3, 8'h04, 1'b0);
    repeat (3) @(posedge clk);
    #2 total_cnt++;
    if (sb.size() != 0) $display("FAIL drain: got %0d pending, want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
